pet_state_core: RTL and testbench
=================================

# pet_state_core

Upstream pet-logic stage for the LCD figure controller. Holds four pet stats: health, food, energy and fun. Each stat decays on a programmable tick and is restored by player buttons. The block encodes mood and the most urgent need into `select_figures[3:0]`, which drives the LCD controller's figure selection, and provides the `ready_o` level the LCD controller waits on. Also implements the sleep and death behaviour of the pet.

## Interface
- `TICK_MAX`, 50_000_000: clk cycles per decay tick.
- `STAT_MAX`, 5: saturation ceiling of every stat.
- `STAT_INIT`, 3: reset value of every stat.
- `BOOST`, 2: increment applied per accepted button event.
- `HAPPY_TH`, 4: mood happy when min stat ≥ HAPPY_TH.
- `SAD_TH`, 1: mood sad when min stat ≤ SAD_TH.
- `clk` in 1: system clock.
- `reset` in 1: reset reset, synchronous, active-low; clock clk.
- `btn_feed`, `btn_play`, `btn_sleep`, `btn_heal` in 1 each: debounced, synchronized, active-high levels.
- `select_figures` out 4: [3:2] mood (00 sad, 01 happy, 10 neutral); [1:0] need (00 health, 01 energy, 10 food, 11 fun).
- `ready_o` out 1: display-ready level for the LCD controller.
- `sleeping_o` out 1: high in SLEEPING.
- `dead_o` out 1: high in DEAD.
- `stat_health`, `stat_food`, `stat_energy`, `stat_fun` out W each: W = $clog2(STAT_MAX+1).

## Operation
- **FSM states:** AWAKE (reset state), SLEEPING, DEAD.
  - AWAKE→SLEEPING on a sleep event.
  - SLEEPING→AWAKE on a sleep event, or when energy becomes STAT_MAX.
  - Any state→DEAD when the updated health is 0. DEAD exits only via reset.
- **Button events:** event = btn & ~btn_q. Edge registers reset to 1, so a button held through reset produces no event.
- **Tick counter:** counts 0..TICK_MAX-1 and wraps. `tick` is asserted for the one cycle when count = TICK_MAX-1.
  - A half flag toggles on every tick and resets to 0.
  - `etick` = tick & half flag, i.e. the 2nd, 4th, … tick.
- **AWAKE updates on tick:**
  - food −1 and fun −1.
  - energy −1 on etick only.
  - health −1 if any of food, energy or fun was 0 before this update (old values).
- **SLEEPING updates on tick:**
  - food −1.
  - energy +1.
  - fun frozen.
  - Health rule unchanged.
  - Play events are ignored; feed, heal and sleep events are accepted.
- **Button boosts:** feed → food +BOOST, play → fun +BOOST, heal → health +BOOST.
- **Update arithmetic:** per stat, new = min(STAT_MAX, max(0, old − dec) + inc). Decay and boost in the same cycle both apply, decay first. Use a width of W+1 internally so no wrap-around occurs.
- **DEAD:**
  - Stats frozen and all events ignored.
  - `select_figures` = 4'b0000.
  - `dead_o` = 1.
- **Encoding (registered from the current stats):**
  - mood = 01 if min ≥ HAPPY_TH; else 00 if min ≤ SAD_TH; else 10.
  - need = index of the minimum stat. Tie priority: health > food > energy > fun.
- **ready_o:** 0 during reset, 1 from the first cycle after reset release, and stays 1 in every state (including DEAD). The LCD controller samples on its slow clock, so this is a level, not a pulse.

## Timing
- Reset values:
  - All stats = STAT_INIT.
  - FSM = AWAKE.
  - Tick counter = 0, half flag = 0.
  - `select_figures` = 4'b1000 (neutral; equal stats give need = health).
  - `ready_o`, `sleeping_o` and `dead_o` = 0.
- Latency:
  - A button high at edge n and low at edge n−1 updates the stat at edge n+1.
  - `select_figures` updates at edge n+2.
  - A tick at count = TICK_MAX-1 updates stats on that same edge; `select_figures` follows one edge later.
- A sleep event and auto-wake in the same cycle: the FSM goes to AWAKE.
- A health update to 0 takes priority over any sleep transition.
- Reset asserted mid-operation overrides everything on the next edge.

## Structure
- Package `pet_state_pkg` holds:
  - FSM state encodings.
  - Mood codes MOOD_SAD/HAPPY/NEUTRAL.
  - Need codes NEED_HEALTH/ENERGY/FOOD/FUN. These must match the LCD controller's `select_figures` mapping.
- One sub-module, `btn_edge`, a parametric rising-edge detector with reset value 1, instantiated four times.
- Tick counter, stat datapath, FSM and encoder live in the top module.

## Test plan
Common parameters: STAT_MAX=5, STAT_INIT=3, BOOST=2, HAPPY_TH=4, SAD_TH=1.
- **Reset and boost** (TICK_MAX=1000): release reset → stats 3/3/3/3, `select_figures`=1000, `ready_o`=1. Apply feed twice → food 5 then saturates at 5. Apply play → fun 5. Apply heal → health 5.
- **Mood flip** (TICK_MAX=1000): apply feed, play, heal, then sleep to raise energy → once min ≥ 4, mood becomes 01.
- **Decay** (TICK_MAX=4, no buttons):
  - Tick1 → food/fun 2, energy 3.
  - Tick2 → food/fun 1, energy 2, `select_figures`=0010.
- **Death** (continue the decay case):
  - Tick3 → food/fun 0, health still 3.
  - Ticks 4, 5, 6 → health 2, 1, 0.
  - Then DEAD: `dead_o`=1, `select_figures`=0000. Feed and heal are ignored afterwards.
- **Sleep:** apply sleep with energy=3 → `sleeping_o`=1. Each tick gives energy +1 and fun unchanged; play is ignored. At energy=5 → auto AWAKE.
- **Simultaneous events:** feed event coincident with a tick at food=3 → food=4. Feed at food=5 with a tick → food=5.

Source files
------------

// File: rtl/pet_state_pkg.sv
// Shared encodings for the pet-logic stage: FSM states and the
// mood/need codes that form select_figures for the LCD figure controller.
package pet_state_pkg;

    // Pet life-cycle states.
    typedef enum logic [1:0] {
        ST_AWAKE    = 2'b00,
        ST_SLEEPING = 2'b01,
        ST_DEAD     = 2'b10
    } pet_state_t;

    // Mood field, select_figures[3:2].
    typedef enum logic [1:0] {
        MOOD_SAD     = 2'b00,
        MOOD_HAPPY   = 2'b01,
        MOOD_NEUTRAL = 2'b10
    } mood_t;

    // Need field, select_figures[1:0]; must stay aligned with the LCD figure map.
    typedef enum logic [1:0] {
        NEED_HEALTH = 2'b00,
        NEED_ENERGY = 2'b01,
        NEED_FOOD   = 2'b10,
        NEED_FUN    = 2'b11
    } need_t;

    // Figure code shown while the pet is dead.
    localparam logic [3:0] FIGURES_DEAD = 4'b0000;

    // Combine mood and need into the figure-select code.
    function automatic logic [3:0] pack_figures(input mood_t mood, input need_t need);
        return {mood, need};
    endfunction

endpackage

// File: rtl/btn_edge.sv
// Registered rising-edge detector for debounced button levels.
// The history register resets to 1 so a button held through reset
// does not generate an event when reset is released.
module btn_edge #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_btn,
    output logic [WIDTH-1:0] o_event
);

    logic [WIDTH-1:0] r_btn_q;
    logic [WIDTH-1:0] r_event;

    // Track the previous level and register a one-cycle event on a 0->1 change.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments let every flop sample pre-edge values, so r_event sees the old r_btn_q.
        if (!reset) begin
            r_btn_q <= '1;
            r_event <= '0;
        end else begin
            r_btn_q <= i_btn;
            r_event <= i_btn & ~r_btn_q;
        end
    end

    assign o_event = r_event;

endmodule

// File: rtl/pet_state_core.sv
// Pet-logic stage for the LCD figure controller: four decaying stats
// restored by buttons, an AWAKE/SLEEPING/DEAD life cycle, and a registered
// mood/need encoding on select_figures.
module pet_state_core
    import pet_state_pkg::*;
#(
    parameter int  TICK_MAX  = 50_000_000,
    parameter int  STAT_MAX  = 5,
    parameter int  STAT_INIT = 3,
    parameter int  BOOST     = 2,
    parameter int  HAPPY_TH  = 4,
    parameter int  SAD_TH    = 1,
    localparam int W         = $clog2(STAT_MAX + 1)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         btn_feed,
    input  logic         btn_play,
    input  logic         btn_sleep,
    input  logic         btn_heal,
    output logic [3:0]   select_figures,
    output logic         ready_o,
    output logic         sleeping_o,
    output logic         dead_o,
    output logic [W-1:0] stat_health,
    output logic [W-1:0] stat_food,
    output logic [W-1:0] stat_energy,
    output logic [W-1:0] stat_fun
);

    localparam int             CW         = (TICK_MAX > 1) ? $clog2(TICK_MAX) : 1;
    localparam logic [CW-1:0]  CNT_LAST   = CW'(TICK_MAX - 1);
    localparam logic [W-1:0]   STAT_MAX_W = W'(STAT_MAX);
    localparam logic [W-1:0]   STAT_INIT_W= W'(STAT_INIT);
    localparam logic [W-1:0]   BOOST_W    = W'(BOOST);
    localparam logic [W-1:0]   HAPPY_W    = W'(HAPPY_TH);
    localparam logic [W-1:0]   SAD_W      = W'(SAD_TH);
    localparam logic [W:0]     STAT_MAX_E = (W+1)'(STAT_MAX);
    localparam logic [W:0]     ONE_E      = (W+1)'(1);

    // Decay first (floored at 0), then boost, then clamp; one spare bit avoids wrap.
    function automatic logic [W-1:0] sat_update(input logic [W-1:0] old_v,
                                                input logic         dec,
                                                input logic [W-1:0] inc);
        logic [W:0] v;
        v = {1'b0, old_v};
        if (dec && (v != '0)) v = v - ONE_E;
        v = v + {1'b0, inc};
        if (v > STAT_MAX_E) v = STAT_MAX_E;
        return v[W-1:0];
    endfunction

    // ------------------------------------------------------------------
    // Button events
    // ------------------------------------------------------------------
    logic w_ev_feed;
    logic w_ev_play;
    logic w_ev_sleep;
    logic w_ev_heal;

    btn_edge #(.WIDTH(1)) u_edge_feed  (.clk(clk), .reset(reset), .i_btn(btn_feed),  .o_event(w_ev_feed));
    btn_edge #(.WIDTH(1)) u_edge_play  (.clk(clk), .reset(reset), .i_btn(btn_play),  .o_event(w_ev_play));
    btn_edge #(.WIDTH(1)) u_edge_sleep (.clk(clk), .reset(reset), .i_btn(btn_sleep), .o_event(w_ev_sleep));
    btn_edge #(.WIDTH(1)) u_edge_heal  (.clk(clk), .reset(reset), .i_btn(btn_heal),  .o_event(w_ev_heal));

    // ------------------------------------------------------------------
    // Decay tick: tick every TICK_MAX cycles, etick on every second tick
    // ------------------------------------------------------------------
    logic [CW-1:0] r_cnt;
    logic          r_half;
    logic          w_tick;
    logic          w_etick;

    assign w_tick  = (r_cnt == CNT_LAST);
    assign w_etick = w_tick & r_half;

    // Free-running tick counter with a half flag toggled on each tick.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt  <= '0;
            r_half <= 1'b0;
        end else begin
            if (w_tick) begin
                r_cnt  <= '0;
                r_half <= ~r_half;
            end else begin
                r_cnt  <= r_cnt + CW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stat datapath
    // ------------------------------------------------------------------
    pet_state_t   r_state;
    logic [W-1:0] r_health;
    logic [W-1:0] r_food;
    logic [W-1:0] r_energy;
    logic [W-1:0] r_fun;

    logic         w_awake;
    logic         w_asleep;
    logic         w_alive;
    logic         w_any_zero;
    logic         w_dec_health;
    logic         w_dec_food;
    logic         w_dec_energy;
    logic         w_dec_fun;
    logic [W-1:0] w_inc_health;
    logic [W-1:0] w_inc_food;
    logic [W-1:0] w_inc_energy;
    logic [W-1:0] w_inc_fun;
    logic [W-1:0] w_health_next;
    logic [W-1:0] w_food_next;
    logic [W-1:0] w_energy_next;
    logic [W-1:0] w_fun_next;

    assign w_awake  = (r_state == ST_AWAKE);
    assign w_asleep = (r_state == ST_SLEEPING);
    assign w_alive  = w_awake | w_asleep;

    // Health suffers when any other stat was already empty before this update.
    assign w_any_zero   = (r_food == '0) || (r_energy == '0) || (r_fun == '0);

    assign w_dec_health = w_alive & w_tick & w_any_zero;
    assign w_dec_food   = w_alive & w_tick;
    assign w_dec_energy = w_awake & w_etick;
    assign w_dec_fun    = w_awake & w_tick;

    // Play is only honoured while awake; sleeping regains one energy per tick.
    assign w_inc_health = (w_alive & w_ev_heal) ? BOOST_W : '0;
    assign w_inc_food   = (w_alive & w_ev_feed) ? BOOST_W : '0;
    assign w_inc_energy = (w_asleep & w_tick)   ? W'(1)   : '0;
    assign w_inc_fun    = (w_awake & w_ev_play) ? BOOST_W : '0;

    assign w_health_next = sat_update(r_health, w_dec_health, w_inc_health);
    assign w_food_next   = sat_update(r_food,   w_dec_food,   w_inc_food);
    assign w_energy_next = sat_update(r_energy, w_dec_energy, w_inc_energy);
    assign w_fun_next    = sat_update(r_fun,    w_dec_fun,    w_inc_fun);

    // Stat registers; in DEAD every decrement and boost is gated off, so they hold.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_health <= STAT_INIT_W;
            r_food   <= STAT_INIT_W;
            r_energy <= STAT_INIT_W;
            r_fun    <= STAT_INIT_W;
        end else begin
            r_health <= w_health_next;
            r_food   <= w_food_next;
            r_energy <= w_energy_next;
            r_fun    <= w_fun_next;
        end
    end

    // ------------------------------------------------------------------
    // Life-cycle FSM with registered status outputs
    // ------------------------------------------------------------------
    logic r_sleeping;
    logic r_dead;

    // Death beats any sleep transition; a sleep event and auto-wake both land in AWAKE.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= ST_AWAKE;
            r_sleeping <= 1'b0;
            r_dead     <= 1'b0;
        end else begin
            unique case (r_state)
                ST_AWAKE: begin
                    if (w_health_next == '0) begin
                        r_state <= ST_DEAD;
                        r_dead  <= 1'b1;
                    end else if (w_ev_sleep) begin
                        r_state    <= ST_SLEEPING;
                        r_sleeping <= 1'b1;
                    end
                end
                ST_SLEEPING: begin
                    if (w_health_next == '0) begin
                        r_state    <= ST_DEAD;
                        r_sleeping <= 1'b0;
                        r_dead     <= 1'b1;
                    end else if (w_ev_sleep || (w_energy_next == STAT_MAX_W)) begin
                        r_state    <= ST_AWAKE;
                        r_sleeping <= 1'b0;
                    end
                end
                ST_DEAD: begin
                    r_state    <= ST_DEAD;
                    r_sleeping <= 1'b0;
                    r_dead     <= 1'b1;
                end
                default: begin
                    r_state    <= ST_AWAKE;
                    r_sleeping <= 1'b0;
                    r_dead     <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Mood / need encoder
    // ------------------------------------------------------------------
    logic [W-1:0] w_min;
    need_t        w_need;
    mood_t        w_mood;

    // Find the lowest stat; strict compares in priority order resolve ties.
    always_comb begin
        // NOTE: every variable gets a value before any branch so no latch is inferred.
        w_min  = r_health;
        w_need = NEED_HEALTH;
        w_mood = MOOD_NEUTRAL;
        if (r_food < w_min) begin
            w_min  = r_food;
            w_need = NEED_FOOD;
        end
        if (r_energy < w_min) begin
            w_min  = r_energy;
            w_need = NEED_ENERGY;
        end
        if (r_fun < w_min) begin
            w_min  = r_fun;
            w_need = NEED_FUN;
        end
        if (w_min >= HAPPY_W) begin
            w_mood = MOOD_HAPPY;
        end else if (w_min <= SAD_W) begin
            w_mood = MOOD_SAD;
        end
    end

    logic [3:0] r_figures;
    logic       r_ready;

    // Register the figure code one edge behind the stats, and the display-ready level.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_figures <= pack_figures(MOOD_NEUTRAL, NEED_HEALTH);
            r_ready   <= 1'b0;
        end else begin
            r_figures <= (r_state == ST_DEAD) ? FIGURES_DEAD : pack_figures(w_mood, w_need);
            r_ready   <= 1'b1;
        end
    end

    assign select_figures = r_figures;
    assign ready_o        = r_ready;
    assign sleeping_o     = r_sleeping;
    assign dead_o         = r_dead;
    assign stat_health    = r_health;
    assign stat_food      = r_food;
    assign stat_energy    = r_energy;
    assign stat_fun       = r_fun;

endmodule

// File: tb/tb_pet_state_core.sv
// Scoreboard bench for pet_state_core: stimulus pushes hand-computed
// expectations, a negedge monitor pops and compares them.
module tb_pet_state_core;

    localparam int TM = 200;
    localparam int W  = 3;

    localparam int S_HEALTH = 0;
    localparam int S_FOOD   = 1;
    localparam int S_ENERGY = 2;
    localparam int S_FUN    = 3;
    localparam int S_SEL    = 4;
    localparam int S_READY  = 5;
    localparam int S_SLEEP  = 6;
    localparam int S_DEAD   = 7;

    localparam int B_FEED  = 0;
    localparam int B_PLAY  = 1;
    localparam int B_SLEEP = 2;
    localparam int B_HEAL  = 3;
    localparam int B_NONE  = -1;

    logic         clk       = 1'b0;
    logic         reset     = 1'b0;
    logic         btn_feed  = 1'b0;
    logic         btn_play  = 1'b0;
    logic         btn_sleep = 1'b0;
    logic         btn_heal  = 1'b0;
    logic [3:0]   select_figures;
    logic         ready_o;
    logic         sleeping_o;
    logic         dead_o;
    logic [W-1:0] stat_health;
    logic [W-1:0] stat_food;
    logic [W-1:0] stat_energy;
    logic [W-1:0] stat_fun;

    pet_state_core #(
        .TICK_MAX (TM),
        .STAT_MAX (5),
        .STAT_INIT(3),
        .BOOST    (2),
        .HAPPY_TH (4),
        .SAD_TH   (1)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .btn_feed      (btn_feed),
        .btn_play      (btn_play),
        .btn_sleep     (btn_sleep),
        .btn_heal      (btn_heal),
        .select_figures(select_figures),
        .ready_o       (ready_o),
        .sleeping_o    (sleeping_o),
        .dead_o        (dead_o),
        .stat_health   (stat_health),
        .stat_food     (stat_food),
        .stat_energy   (stat_energy),
        .stat_fun      (stat_fun)
    );

    always #5 clk = ~clk;

    typedef struct {
        int    cyc;
        string name;
        int    sig;
        int    val;
    } exp_t;

    exp_t sb_q[$];
    int   gcyc      = 0;
    int   edge_no   = 0;
    int   checks    = 0;
    int   errors    = 0;
    logic end_check = 1'b0;
    logic end_done  = 1'b0;

    always @(posedge clk) gcyc <= gcyc + 1;

    function automatic int sig_value(input int sig);
        case (sig)
            S_HEALTH: return int'(stat_health);
            S_FOOD:   return int'(stat_food);
            S_ENERGY: return int'(stat_energy);
            S_FUN:    return int'(stat_fun);
            S_SEL:    return int'(select_figures);
            S_READY:  return int'(ready_o);
            S_SLEEP:  return int'(sleeping_o);
            S_DEAD:   return int'(dead_o);
            default:  return -1;
        endcase
    endfunction

    // Monitor: pop every due expectation and compare against the live outputs.
    always @(negedge clk) begin : monitor
        exp_t e;
        int   act;
        while (sb_q.size() > 0 && sb_q[0].cyc <= gcyc) begin
            e   = sb_q.pop_front();
            act = sig_value(e.sig);
            checks++;
            if (act !== e.val) begin
                errors++;
                $display("FAIL %s: got %0d, expected %0d", e.name, act, e.val);
            end
        end
        if (end_check && !end_done) begin
            end_done = 1'b1;
            checks++;
            if (sb_q.size() != 0) begin
                errors++;
                $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb_q.size());
            end
        end
    end

    task automatic exp_push(input string name, input int sig, input int val);
        exp_t e;
        e.cyc  = gcyc;
        e.name = name;
        e.sig  = sig;
        e.val  = val;
        sb_q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            edge_no++;
        end
    endtask

    task automatic run_to(input int e);
        if (e > edge_no) step(e - edge_no);
    endtask

    task automatic set_btn(input int id, input logic v);
        case (id)
            B_FEED:  btn_feed  = v;
            B_PLAY:  btn_play  = v;
            B_SLEEP: btn_sleep = v;
            B_HEAL:  btn_heal  = v;
            default: ;
        endcase
    endtask

    // One-cycle press: event registered at the first edge, stat updated at the second.
    task automatic press(input int id);
        set_btn(id, 1'b1);
        step(1);
        set_btn(id, 1'b0);
        step(1);
    endtask

    task automatic apply_reset(input int hold_id);
        reset = 1'b0;
        btn_feed = 1'b0; btn_play = 1'b0; btn_sleep = 1'b0; btn_heal = 1'b0;
        if (hold_id >= 0) set_btn(hold_id, 1'b1);
        step(1);
        exp_push("rst_health", S_HEALTH, 3);
        exp_push("rst_food",   S_FOOD,   3);
        exp_push("rst_energy", S_ENERGY, 3);
        exp_push("rst_fun",    S_FUN,    3);
        exp_push("rst_sel",    S_SEL,    4'b1000);
        exp_push("rst_ready",  S_READY,  0);
        exp_push("rst_sleep",  S_SLEEP,  0);
        exp_push("rst_dead",   S_DEAD,   0);
        step(2);
        reset   = 1'b1;
        edge_no = 0;
    endtask

    initial begin
        // ---------------- Reset and boost, mood flip, simultaneous events
        apply_reset(B_FEED);
        step(1);
        exp_push("ready_after_release", S_READY, 1);
        step(1);
        exp_push("held_through_reset", S_FOOD, 3);
        set_btn(B_FEED, 1'b0);
        step(1);
        press(B_FEED);
        exp_push("feed_boost", S_FOOD, 5);
        press(B_FEED);
        exp_push("feed_saturate", S_FOOD, 5);
        press(B_PLAY);
        exp_push("play_boost", S_FUN, 5);
        press(B_HEAL);
        exp_push("heal_boost", S_HEALTH, 5);
        step(1);
        exp_push("sel_need_energy", S_SEL, 4'b1001);
        press(B_SLEEP);
        exp_push("sleep_enter", S_SLEEP, 1);
        run_to(TM);
        exp_push("sleep_t1_energy", S_ENERGY, 4);
        exp_push("sleep_t1_food",   S_FOOD,   4);
        exp_push("sleep_t1_fun",    S_FUN,    5);
        exp_push("sleep_t1_still",  S_SLEEP,  1);
        step(1);
        exp_push("mood_happy", S_SEL, 4'b0110);
        run_to(2*TM);
        exp_push("auto_wake_energy", S_ENERGY, 5);
        exp_push("auto_wake",        S_SLEEP,  0);
        step(1);
        exp_push("sel_neutral_food", S_SEL, 4'b1010);
        run_to(3*TM - 2);
        set_btn(B_FEED, 1'b1);
        step(1);
        set_btn(B_FEED, 1'b0);
        step(1);
        exp_push("feed_with_tick",      S_FOOD,   4);
        exp_push("awake_tick_fun",      S_FUN,    4);
        exp_push("odd_tick_energy",     S_ENERGY, 5);
        press(B_FEED);
        exp_push("feed_to_max", S_FOOD, 5);
        run_to(4*TM - 2);
        set_btn(B_FEED, 1'b1);
        step(1);
        set_btn(B_FEED, 1'b0);
        step(1);
        exp_push("feed_tick_at_max",   S_FOOD,   5);
        exp_push("even_tick_energy",   S_ENERGY, 4);

        // ---------------- Decay and death
        apply_reset(B_NONE);
        run_to(TM);
        exp_push("decay_t1_food",   S_FOOD,   2);
        exp_push("decay_t1_fun",    S_FUN,    2);
        exp_push("decay_t1_energy", S_ENERGY, 3);
        run_to(2*TM);
        exp_push("decay_t2_food",   S_FOOD,   1);
        exp_push("decay_t2_energy", S_ENERGY, 2);
        step(1);
        exp_push("decay_t2_sel", S_SEL, 4'b0010);
        run_to(3*TM);
        exp_push("decay_t3_food",   S_FOOD,   0);
        exp_push("decay_t3_fun",    S_FUN,    0);
        exp_push("decay_t3_health", S_HEALTH, 3);
        run_to(4*TM);
        exp_push("decay_t4_health", S_HEALTH, 2);
        exp_push("decay_t4_energy", S_ENERGY, 1);
        run_to(5*TM);
        exp_push("decay_t5_health", S_HEALTH, 1);
        exp_push("decay_t5_alive",  S_DEAD,   0);
        run_to(6*TM);
        exp_push("decay_t6_health", S_HEALTH, 0);
        exp_push("death",           S_DEAD,   1);
        step(1);
        exp_push("dead_sel", S_SEL, 4'b0000);
        press(B_FEED);
        press(B_HEAL);
        exp_push("dead_feed_ignored", S_FOOD,   0);
        exp_push("dead_heal_ignored", S_HEALTH, 0);
        exp_push("dead_ready",        S_READY,  1);
        run_to(7*TM);
        exp_push("dead_frozen_energy", S_ENERGY, 0);
        exp_push("dead_stays",         S_DEAD,   1);

        // ---------------- Sleep behaviour (reset also leaves DEAD)
        apply_reset(B_NONE);
        step(1);
        press(B_SLEEP);
        exp_push("sleep_at_e3", S_SLEEP, 1);
        press(B_PLAY);
        exp_push("play_ignored_sleep", S_FUN, 3);
        press(B_HEAL);
        exp_push("heal_in_sleep", S_HEALTH, 5);
        press(B_FEED);
        exp_push("feed_in_sleep", S_FOOD, 5);
        run_to(TM);
        exp_push("sleep2_t1_energy", S_ENERGY, 4);
        exp_push("sleep2_t1_fun",    S_FUN,    3);
        exp_push("sleep2_t1_food",   S_FOOD,   4);
        run_to(2*TM);
        exp_push("sleep2_t2_energy", S_ENERGY, 5);
        exp_push("sleep2_t2_fun",    S_FUN,    3);
        exp_push("sleep2_auto_wake", S_SLEEP,  0);

        step(2);
        end_check = 1'b1;
        step(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
